// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver for an HH:MM clock.
// Guard-blanked digit slots, frame-latched digits, leading-zero blank, colon.
module seven_seg_scan #(
  parameter int c_REFRESH_DIV = 50000,
  parameter int c_GUARD       = 16,
  parameter int c_ACTIVE_LOW  = 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [15:0] i_Digits,
  input  logic        i_Blank_Leading,
  input  logic        i_Colon_Tick,
  output logic [6:0]  o_Segments,
  output logic        o_Colon,
  output logic [3:0]  o_Anodes
);

  localparam int PW =
    (c_REFRESH_DIV > 2) ? $clog2(c_REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST  = PW'(c_REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD = PW'(c_GUARD);
  localparam logic          INV   = 1'(c_ACTIVE_LOW != 0);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          colon;

  logic [3:0] nib;
  logic [6:0] glyph;
  logic       wrap;
  logic       in_guard;
  logic       blank;

  always_comb begin
    nib = 4'd0;
    case (idx)
      2'd0:    nib = snap[3:0];
      2'd1:    nib = snap[7:4];
      2'd2:    nib = snap[11:8];
      default: nib = snap[15:12];
    endcase
  end

  // active-high glyphs, bit order {g,f,e,d,c,b,a}
  always_comb begin
    glyph = 7'b1000000;
    case (nib)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b1000000;
    endcase
  end

  always_comb begin
    wrap     = (presc == LAST);
    in_guard = (presc < GUARD);
    blank    = i_Blank_Leading && (idx == 2'd3) &&
               (nib == 4'd0);
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      presc      <= '0;
      idx        <= 2'd0;
      snap       <= 16'h0000;
      colon      <= 1'b1;
      o_Anodes   <= {4{INV}};
      o_Segments <= {7{INV}};
      o_Colon    <= INV;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      if (wrap)
        idx <= idx + 2'd1;
      // latch once per frame so a digit change never tears
      if (presc == '0 && idx == 2'd0)
        snap <= i_Digits;
      if (i_Colon_Tick)
        colon <= ~colon;

      if (in_guard) begin
        o_Anodes   <= {4{INV}};
        o_Segments <= {7{INV}};
        o_Colon    <= INV;
      end else begin
        o_Anodes   <= (4'b0001 << idx) ^ {4{INV}};
        o_Segments <= (blank ? 7'b0000000 : glyph) ^ {7{INV}};
        o_Colon    <= ((idx == 2'd2) && colon) ^ INV;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DIV=8, GUARD=2, active-low.
// Expected outputs come from hand-written active-low glyph constants.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic        blank_lead;
  logic        tick;
  logic [6:0]  segs;
  logic        colon_o;
  logic [3:0]  anodes;

  int n_checks = 0;
  int n_err    = 0;

  int          t;
  logic [15:0] exp_snap;
  logic        exp_colon;

  seven_seg_scan #(
    .c_REFRESH_DIV(8),
    .c_GUARD      (2),
    .c_ACTIVE_LOW (1)
  ) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Digits       (digits),
    .i_Blank_Leading(blank_lead),
    .i_Colon_Tick   (tick),
    .o_Segments     (segs),
    .o_Colon        (colon_o),
    .o_Anodes       (anodes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph_lo(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // one edge since release: outputs show the pre-edge slot position
  task automatic cyc();
    int pos, slot, w;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ec;
    pos  = t % 32;
    slot = pos / 8;
    w    = pos % 8;
    nib  = exp_snap[slot*4 +: 4];
    if (w < 2) begin
      ea = 4'b1111;
      es = 7'b1111111;
      ec = 1'b1;
    end else begin
      ea = ~(4'b0001 << slot);
      if (slot == 3 && blank_lead && nib == 4'd0)
        es = 7'b1111111;
      else
        es = glyph_lo(nib);
      ec = !(slot == 2 && exp_colon);
    end
    if (pos == 0)
      exp_snap = digits;
    if (tick)
      exp_colon = ~exp_colon;
    @(posedge clk);
    #1;
    check($sformatf("anodes t=%0d", t), {12'd0, anodes}, {12'd0, ea});
    check($sformatf("segs t=%0d", t), {9'd0, segs}, {9'd0, es});
    check($sformatf("colon t=%0d", t), {15'd0, colon_o}, {15'd0, ec});
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic reset_edge(input string tag);
    @(posedge clk);
    #1;
    check({tag, " anodes"}, {12'd0, anodes}, 16'h000f);
    check({tag, " segs"}, {9'd0, segs}, 16'h007f);
    check({tag, " colon"}, {15'd0, colon_o}, 16'h0001);
  endtask

  initial begin
    rst_n      = 1'b0;
    digits     = 16'h1234;
    blank_lead = 1'b0;
    tick       = 1'b0;
    reset_edge("rst0");
    tick = 1'b1;
    reset_edge("rst1");
    tick = 1'b0;

    t         = 0;
    exp_snap  = 16'h0000;
    exp_colon = 1'b1;
    rst_n     = 1'b1;
    run(35);

    digits = 16'h5678;
    run(65);

    digits     = 16'h0930;
    blank_lead = 1'b1;
    run(60);
    blank_lead = 1'b0;
    run(32);

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    run(40);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    run(40);

    digits = 16'h00a0;
    while (t % 32 != 0) cyc();
    run(13);
    check("dash seen", {9'd0, segs}, 16'h003f);
    check("dash anode", {12'd0, anodes}, 16'h000d);

    rst_n = 1'b0;
    reset_edge("midrst");
    t         = 0;
    exp_snap  = 16'h0000;
    exp_colon = 1'b1;
    rst_n     = 1'b1;
    digits    = 16'h1234;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
